// File: rtl/rx_interrupt_coalesce.sv
// rx_interrupt_coalesce: per-channel Rx interrupt coalescing with round-robin req/ack arbitration; RX_INTR_MASK_EN adds intr_mask
module rx_interrupt_coalesce #(
    parameter int NUM_CH      = 4,
    parameter int PTR_W       = 64,
    parameter int CNT_W       = 16,
    parameter int TMR_W       = 16,
    parameter int SYNC_STAGES = 2,
    localparam int VW         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       rx_activity,
    input  logic [NUM_CH*PTR_W-1:0] hw_pointer,
    input  logic [NUM_CH*PTR_W-1:0] sw_pointer,
    input  logic [NUM_CH-1:0]       huge_page_status_1,
    input  logic [NUM_CH-1:0]       huge_page_status_2,
    input  logic [CNT_W-1:0]        coal_pkt_thresh,
    input  logic [TMR_W-1:0]        coal_timeout,
    input  logic                    intr_ack,
`ifdef RX_INTR_MASK_EN
    input  logic [NUM_CH-1:0]       intr_mask,
`endif
    output logic                    send_interrupt,
    output logic [VW-1:0]           intr_vector
);
    typedef enum logic [1:0] {WAIT_PAGE, ARMED, ACCUM, FIRE} state_t;
    logic [NUM_CH-1:0] fire_vec, elig;
    logic [VW-1:0]     rr, pick;
    logic [CNT_W-1:0]  thr_eff;
    assign thr_eff = coal_pkt_thresh == '0 ? CNT_W'(1) : coal_pkt_thresh;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [SYNC_STAGES:0] sh;
        logic                 ev, ptr_ne, ack_c, hit;
        state_t               st;
        logic [CNT_W-1:0]     cnt, cnt_inc;
        logic [TMR_W-1:0]     tmr, tmr_inc;
        assign ptr_ne  = hw_pointer[c*PTR_W +: PTR_W] != sw_pointer[c*PTR_W +: PTR_W];
        assign ack_c   = intr_ack && send_interrupt && intr_vector == VW'(c);
        assign cnt_inc = (ev && cnt != '1) ? cnt + 1'b1 : cnt;
        assign tmr_inc = tmr != '1 ? tmr + 1'b1 : tmr;
        assign hit     = cnt >= thr_eff || (coal_timeout != '0 && tmr == coal_timeout - TMR_W'(1))
                         || (ptr_ne && coal_pkt_thresh <= CNT_W'(1));
        assign fire_vec[c] = st == FIRE;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sh  <= '0;
                ev  <= 1'b0;
                st  <= WAIT_PAGE;
                cnt <= '0;
                tmr <= '0;
            end else begin
                sh <= {sh[SYNC_STAGES-1:0], rx_activity[c]};
                ev <= sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];
                case (st)
                    WAIT_PAGE: st <= (huge_page_status_1[c] | huge_page_status_2[c]) ? ARMED : WAIT_PAGE;
                    ARMED: if (ev || ptr_ne) begin
                        st  <= ACCUM;
                        cnt <= CNT_W'(ev);
                        tmr <= '0;
                    end
                    ACCUM: begin
                        st  <= hit ? FIRE : ACCUM;
                        cnt <= cnt_inc;
                        tmr <= tmr_inc;
                    end
                    default: begin
                        st  <= !ack_c ? FIRE : (ev || ptr_ne) ? ACCUM : ARMED;
                        cnt <= ack_c ? CNT_W'(ev) : cnt_inc;
                        tmr <= ack_c ? '0 : tmr_inc;
                    end
                endcase
            end
        end
    end
`ifdef RX_INTR_MASK_EN
    assign elig = fire_vec & ~intr_mask;
`else
    assign elig = fire_vec;
`endif
    // lowest offset from rr wins, so scan offsets from the far end down
    always_comb begin
        pick = rr;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (elig[(int'(rr) + i) % NUM_CH]) pick = VW'((int'(rr) + i) % NUM_CH);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            send_interrupt <= 1'b0;
            intr_vector    <= '0;
            rr             <= '0;
        end else if (send_interrupt) begin
            if (intr_ack) begin
                send_interrupt <= 1'b0;
                rr             <= VW'((int'(intr_vector) + 1) % NUM_CH);
            end
        end else if (|elig) begin
            send_interrupt <= 1'b1;
            intr_vector    <= pick;
        end
    end
endmodule

// File: tb/tb_rx_interrupt_coalesce.sv
// tb_rx_interrupt_coalesce: scoreboard bench for rx_interrupt_coalesce (4 channels, 2 sync stages)
module tb_rx_interrupt_coalesce;
    logic         clk, reset_n, intr_ack, send_interrupt;
    logic [3:0]   rx_activity, huge_page_status_1, huge_page_status_2;
    logic [255:0] hw_pointer, sw_pointer;
    logic [15:0]  coal_pkt_thresh, coal_timeout;
    logic [1:0]   intr_vector;
`ifdef RX_INTR_MASK_EN
    logic [3:0]   intr_mask;
`endif
    logic [1:0]   exp_q[$];
    int           pass_cnt, total_cnt;

    rx_interrupt_coalesce dut (
        .clk(clk), .reset_n(reset_n), .rx_activity(rx_activity),
        .hw_pointer(hw_pointer), .sw_pointer(sw_pointer),
        .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
        .coal_pkt_thresh(coal_pkt_thresh), .coal_timeout(coal_timeout), .intr_ack(intr_ack),
`ifdef RX_INTR_MASK_EN
        .intr_mask(intr_mask),
`endif
        .send_interrupt(send_interrupt), .intr_vector(intr_vector)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int c);
        rx_activity[c] = 1'b1;
        tick();
        tick();
        rx_activity[c] = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_send(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (send_interrupt) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic serve(input int budget, output logic got, output logic [1:0] v, output logic dropped);
        v = '0;
        dropped = 1'b0;
        wait_send(budget, got);
        if (got) begin
            v = intr_vector;
            intr_ack = 1'b1;
            tick();
            intr_ack = 1'b0;
            dropped = !send_interrupt;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total_cnt++;
        if (send_interrupt !== 1'b0 || intr_vector !== 2'd0)
            $display("FAIL reset_outputs: observed send=%b vec=%0d expected send=0 vec=0", send_interrupt, intr_vector);
        else pass_cnt++;
        tick();
        tick();
        reset_n = 1'b1;
        idle(5);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL reset_idle: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
    endtask

    task automatic test_wait_page();
        pulse(0);
        pulse(3);
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL wait_page_events: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        huge_page_status_1[0] = 1'b1;
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL page_ready_no_stale: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
    endtask

    task automatic test_latency();
        logic [1:0] e;
        rx_activity[0] = 1'b1;
        exp_q.push_back(2'd0);
        tick();
        idle(4);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL latency_early: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        tick();
        e = exp_q.pop_front();
        total_cnt++;
        if (send_interrupt !== 1'b1 || intr_vector !== e)
            $display("FAIL latency_on: observed send=%b vec=%0d expected send=1 vec=%0d", send_interrupt, intr_vector, e);
        else pass_cnt++;
        intr_ack = 1'b1;
        rx_activity[0] = 1'b0;
        tick();
        intr_ack = 1'b0;
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL ack_drop: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
    endtask

    task automatic test_threshold();
        logic got, dropped;
        logic [1:0] v, e;
        huge_page_status_1 = 4'hF;
        coal_pkt_thresh = 16'd4;
        idle(2);
        repeat (3) pulse(1);
        idle(20);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL thresh_below: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        exp_q.push_back(2'd1);
        pulse(1);
        serve(30, got, v, dropped);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || v !== e) $display("FAIL thresh_fire: observed got=%b vec=%0d expected got=1 vec=%0d", got, v, e);
        else pass_cnt++;
        total_cnt++;
        if (dropped !== 1'b1) $display("FAIL thresh_ack_drop: observed dropped=%b expected 1", dropped);
        else pass_cnt++;
        coal_pkt_thresh = 16'd1;
    endtask

    task automatic test_timeout();
        logic [1:0] e;
        coal_pkt_thresh = 16'd100;
        coal_timeout = 16'd50;
        rx_activity[2] = 1'b1;
        exp_q.push_back(2'd2);
        tick();
        idle(53);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL timeout_early: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        tick();
        e = exp_q.pop_front();
        total_cnt++;
        if (send_interrupt !== 1'b1 || intr_vector !== e)
            $display("FAIL timeout_fire: observed send=%b vec=%0d expected send=1 vec=%0d", send_interrupt, intr_vector, e);
        else pass_cnt++;
        intr_ack = 1'b1;
        rx_activity[2] = 1'b0;
        tick();
        intr_ack = 1'b0;
        coal_pkt_thresh = 16'd1;
        coal_timeout = 16'd0;
    endtask

    task automatic test_round_robin();
        logic got, dropped;
        logic [1:0] v, e;
        do_reset();
        rx_activity = 4'hF;
        for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
        tick();
        tick();
        rx_activity = 4'h0;
        for (int k = 0; k < 5; k++) begin
            serve(40, got, v, dropped);
            e = exp_q.pop_front();
            total_cnt++;
            if (got !== 1'b1 || v !== e) $display("FAIL rr_grant_%0d: observed got=%b vec=%0d expected got=1 vec=%0d", k, got, v, e);
            else pass_cnt++;
            total_cnt++;
            if (dropped !== 1'b1) $display("FAIL rr_drop_%0d: observed dropped=%b expected 1", k, dropped);
            else pass_cnt++;
            if (k == 0) begin
                rx_activity[0] = 1'b1;
                exp_q.push_back(2'd0);
            end
            if (k == 2) rx_activity[0] = 1'b0;
        end
    endtask

    task automatic test_reraise();
        logic got, dropped;
        logic [1:0] v, e;
        hw_pointer[63:0] = 64'h1;
        exp_q.push_back(2'd0);
        serve(30, got, v, dropped);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || v !== e) $display("FAIL ptr_first: observed got=%b vec=%0d expected got=1 vec=%0d", got, v, e);
        else pass_cnt++;
        exp_q.push_back(2'd0);
        wait_send(20, got);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || intr_vector !== e) $display("FAIL ptr_reraise: observed got=%b vec=%0d expected got=1 vec=%0d", got, intr_vector, e);
        else pass_cnt++;
        hw_pointer[63:0] = 64'h0;
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL ptr_settled: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        coal_pkt_thresh = 16'd2;
        pulse(0);
        pulse(0);
        wait_send(30, got);
        total_cnt++;
        if (got !== 1'b1) $display("FAIL carry_setup: observed got=%b expected 1", got);
        else pass_cnt++;
        rx_activity[0] = 1'b1;
        idle(3);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        rx_activity[0] = 1'b0;
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL carry_hold: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        exp_q.push_back(2'd0);
        pulse(0);
        serve(30, got, v, dropped);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || v !== e) $display("FAIL carry_fire: observed got=%b vec=%0d expected got=1 vec=%0d", got, v, e);
        else pass_cnt++;
        coal_pkt_thresh = 16'd1;
    endtask

`ifdef RX_INTR_MASK_EN
    task automatic test_mask();
        logic got, dropped;
        logic [1:0] v, e;
        intr_mask = 4'b1000;
        pulse(3);
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL mask_block: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        exp_q.push_back(2'd1);
        pulse(1);
        serve(30, got, v, dropped);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || v !== e) $display("FAIL mask_other: observed got=%b vec=%0d expected got=1 vec=%0d", got, v, e);
        else pass_cnt++;
        idle(10);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL mask_still: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
        exp_q.push_back(2'd3);
        intr_mask = 4'b0000;
        serve(10, got, v, dropped);
        e = exp_q.pop_front();
        total_cnt++;
        if (got !== 1'b1 || v !== e) $display("FAIL mask_unmask: observed got=%b vec=%0d expected got=1 vec=%0d", got, v, e);
        else pass_cnt++;
    endtask
`endif

    task automatic test_async_reset();
        logic got;
        pulse(1);
        wait_send(30, got);
        total_cnt++;
        if (got !== 1'b1 || intr_vector !== 2'd1) $display("FAIL areset_setup: observed got=%b vec=%0d expected got=1 vec=1", got, intr_vector);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (send_interrupt !== 1'b0 || intr_vector !== 2'd0)
            $display("FAIL areset_drop: observed send=%b vec=%0d expected send=0 vec=0", send_interrupt, intr_vector);
        else pass_cnt++;
        tick();
        tick();
        reset_n = 1'b1;
        idle(15);
        total_cnt++;
        if (send_interrupt !== 1'b0) $display("FAIL areset_cleared: observed send=%b expected 0", send_interrupt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset_n = 1'b0;
        intr_ack = 1'b0;
        rx_activity = '0;
        huge_page_status_1 = '0;
        huge_page_status_2 = '0;
        hw_pointer = '0;
        sw_pointer = '0;
        coal_pkt_thresh = 16'd1;
        coal_timeout = 16'd0;
`ifdef RX_INTR_MASK_EN
        intr_mask = '0;
`endif
        test_reset();
        test_wait_page();
        test_latency();
        test_threshold();
        test_timeout();
        test_round_robin();
        test_reraise();
`ifdef RX_INTR_MASK_EN
        test_mask();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
